// File: rtl/mda_vram_arbiter.sv
// Purpose: shares a single-port sync-read character RAM between MDA video fetch and a host req/ack port.
// Latency: video slot -> vid_char_stb is 2 clocks; host grant -> host_ack is 1 clock, grant waits at most 1 clock.
// Backpressure: video slots always win; the host holds host_req until host_ack. Optional macro: VRAM_CURSOR_EN.
module mda_vram_arbiter #(
  parameter int CELL_W = 9,
  parameter int CHAR_H = 14,
  parameter int COLS   = 80,
  parameter int ADDR_W = 11,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_en,
  input  logic              line_end,
  input  logic              frame_start,
  output logic [DATA_W-1:0] vid_char,
  output logic              vid_char_stb,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
`ifdef VRAM_CURSOR_EN
  ,
  input  logic [ADDR_W-1:0] cursor_addr,
  input  logic              cursor_on,
  output logic              vid_cursor
`endif
);

  localparam int PIX_W  = (CELL_W > 1) ? $clog2(CELL_W) : 1;
  localparam int SCAN_W = (CHAR_H > 1) ? $clog2(CHAR_H) : 1;
  localparam logic [PIX_W-1:0]  PIX_LAST  = PIX_W'(CELL_W - 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(CHAR_H - 1);
  localparam logic [ADDR_W-1:0] COLS_A    = ADDR_W'(COLS);

  typedef enum logic {ST_IDLE, ST_DONE} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [PIX_W-1:0]    r_pix_cnt;
  logic [ADDR_W-1:0]   r_col;
  logic [SCAN_W-1:0]   r_scan;
  logic [ADDR_W-1:0]   r_row_base;
  logic                r_line_slot;
  logic                r_vid_pend;
  logic                r_vid_stb;
  logic [DATA_W-1:0]   r_vid_char;
  logic [ADDR_W-1:0]   r_ram_addr_last;
  logic                r_host_we;
  logic [DATA_W-1:0]   r_host_rdata;
  logic                w_slot;
  logic                w_grant;
  logic [ADDR_W-1:0]   w_vid_addr;

  // Slot is the first clock of each cell; reset suppresses every RAM access.
  assign w_slot     = !reset && fetch_en && (r_pix_cnt == '0);
  assign w_vid_addr = r_row_base + r_col;

  // Cell phase counter; holding it at 0 while fetch_en is low makes the first high clock a slot.
  always_ff @(posedge clk) begin
    if (reset || !fetch_en) begin
      r_pix_cnt <= '0;
    end else if (r_pix_cnt == PIX_LAST) begin
      r_pix_cnt <= '0;
    end else begin
      r_pix_cnt <= r_pix_cnt + 1'b1;
    end
  end

  // Column / scanline / row-base tracking; frame_start outranks line_end.
  always_ff @(posedge clk) begin
    if (reset || frame_start) begin
      r_col       <= '0;
      r_scan      <= '0;
      r_row_base  <= '0;
      r_line_slot <= 1'b0;
    end else if (line_end) begin
      r_col       <= '0;
      r_line_slot <= 1'b0;
      if (r_line_slot || w_slot) begin
        if (r_scan == SCAN_LAST) begin
          r_scan     <= '0;
          r_row_base <= r_row_base + COLS_A;
        end else begin
          r_scan <= r_scan + 1'b1;
        end
      end
    end else if (w_slot) begin
      r_col       <= r_col + 1'b1;
      r_line_slot <= 1'b1;
    end
  end

  // Video read pipeline: capture RAM data the clock after the slot, strobe the clock after that.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vid_pend <= 1'b0;
      r_vid_stb  <= 1'b0;
      r_vid_char <= '0;
    end else begin
      r_vid_pend <= w_slot;
      r_vid_stb  <= r_vid_pend;
      if (r_vid_pend) begin
        r_vid_char <= ram_rdata;
      end
    end
  end

  assign vid_char     = r_vid_char;
  assign vid_char_stb = r_vid_stb;

`ifdef VRAM_CURSOR_EN
  logic r_cur_pend;
  logic r_vid_cursor;

  // Cursor match travels beside the character read so it lands with vid_char.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cur_pend   <= 1'b0;
      r_vid_cursor <= 1'b0;
    end else begin
      r_cur_pend <= w_slot && cursor_on && (w_vid_addr == cursor_addr);
      if (r_vid_pend) begin
        r_vid_cursor <= r_cur_pend;
      end
    end
  end

  assign vid_cursor = r_vid_cursor;
`endif

  // Host FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Host FSM next state: grant only on non-slot clocks, DONE lasts exactly one clock.
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!reset && host_req && !w_slot) begin
          w_grant     = 1'b1;
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Remember the direction of the granted access and keep the last read result.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_host_we    <= 1'b0;
      r_host_rdata <= '0;
    end else begin
      if (w_grant) begin
        r_host_we <= host_we;
      end
      if (r_state == ST_DONE && !r_host_we) begin
        r_host_rdata <= ram_rdata;
      end
    end
  end

  // Ack is the DONE clock; read data is passed straight from the RAM during it.
  always_comb begin
    host_ack   = !reset && (r_state == ST_DONE);
    host_rdata = r_host_rdata;
    if (host_ack && !r_host_we) begin
      host_rdata = ram_rdata;
    end
  end

  // One RAM access per clock: video slot, host grant, or idle with the address parked.
  always_comb begin
    ram_addr  = r_ram_addr_last;
    ram_we    = 1'b0;
    ram_wdata = '0;
    if (w_slot) begin
      ram_addr = w_vid_addr;
    end else if (w_grant) begin
      ram_addr  = host_addr;
      ram_we    = host_we;
      ram_wdata = host_wdata;
    end
  end

  // Parked address register so idle clocks repeat the previous address.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ram_addr_last <= '0;
    end else begin
      r_ram_addr_last <= ram_addr;
    end
  end

endmodule

// File: tb/tb_mda_vram_arbiter.sv
// Bench for mda_vram_arbiter: RAM model, behavioural reference model and per-cycle comparison.
// Directed scenarios pin key literal values; a randomized phase exercises video and host together.
module tb_mda_vram_arbiter;

  localparam int CELL_W = 9;
  localparam int CHAR_H = 14;
  localparam int COLS   = 80;
  localparam int ADDR_W = 11;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              fetch_en = 1'b0;
  logic              line_end = 1'b0;
  logic              frame_start = 1'b0;
  logic [DATA_W-1:0] vid_char;
  logic              vid_char_stb;
  logic              host_req = 1'b0;
  logic              host_we = 1'b0;
  logic [ADDR_W-1:0] host_addr = '0;
  logic [DATA_W-1:0] host_wdata = '0;
  logic              host_ack;
  logic [DATA_W-1:0] host_rdata;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata = '0;
`ifdef VRAM_CURSOR_EN
  logic [ADDR_W-1:0] cursor_addr = '0;
  logic              cursor_on = 1'b0;
  logic              vid_cursor;
`endif

  int errors = 0;
  int checks = 0;

  mda_vram_arbiter #(
    .CELL_W(CELL_W), .CHAR_H(CHAR_H), .COLS(COLS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)
  ) dut (
    .clk(clk), .reset(reset), .fetch_en(fetch_en), .line_end(line_end),
    .frame_start(frame_start), .vid_char(vid_char), .vid_char_stb(vid_char_stb),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
`ifdef VRAM_CURSOR_EN
    , .cursor_addr(cursor_addr), .cursor_on(cursor_on), .vid_cursor(vid_cursor)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Synchronous-read RAM seen by the DUT.
  logic [DATA_W-1:0] ram_mem [DEPTH];
  always @(posedge clk) begin
    ram_rdata <= ram_mem[ram_addr];
    if (ram_we === 1'b1) ram_mem[ram_addr] = ram_wdata;
  end

  // Reference model state: contents, lines since frame start, slots in current line, etc.
  logic [DATA_W-1:0] mdl_mem [DEPTH];
  int   fe_age = 0;
  int   lines = 0;
  int   col = 0;
  bit   line_had = 0;
  int   last_addr = 0;
  bit   p1 = 0, p2 = 0;
  logic [DATA_W-1:0] p1_dat = '0, p2_dat = '0, cur_char = '0;
  bit   ack_due = 0, ack_we = 0;
  logic [DATA_W-1:0] ack_dat = '0, held_rd = '0;
  int   rst_cycles = 0;

  always @(negedge clk) begin
    bit   slot, grant;
    int   va;
    logic [DATA_W-1:0] exp_rd;
    if (reset) begin
      if (rst_cycles >= 1) begin
        chk("rst_ram_we", ram_we, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_ram_wdata", ram_wdata, 0);
        chk("rst_vid_char", vid_char, 0);
        chk("rst_vid_stb", vid_char_stb, 0);
        chk("rst_host_ack", host_ack, 0);
        chk("rst_host_rdata", host_rdata, 0);
      end
      rst_cycles++;
      fe_age = 0; lines = 0; col = 0; line_had = 0; last_addr = 0;
      p1 = 0; p2 = 0; cur_char = '0; ack_due = 0; held_rd = '0;
    end else begin
      rst_cycles = 0;
      slot  = fetch_en && ((fe_age % CELL_W) == 0);
      va    = ((lines / CHAR_H) * COLS + col) % DEPTH;
      grant = !ack_due && host_req && !slot;
      if (slot) begin
        chk("vid_ram_we", ram_we, 0);
        chk("vid_ram_addr", ram_addr, va);
      end else if (grant) begin
        chk("host_ram_we", ram_we, host_we);
        chk("host_ram_addr", ram_addr, host_addr);
        if (host_we) chk("host_ram_wdata", ram_wdata, host_wdata);
      end else begin
        chk("idle_ram_we", ram_we, 0);
        chk("idle_ram_addr", ram_addr, last_addr);
      end
      chk("vid_stb", vid_char_stb, p2);
      if (p2) cur_char = p2_dat;
      chk("vid_char", vid_char, cur_char);
      chk("host_ack", host_ack, ack_due);
      exp_rd = (ack_due && !ack_we) ? ack_dat : held_rd;
      chk("host_rdata", host_rdata, exp_rd);
      // advance model across the coming clock edge
      p2 = p1; p2_dat = p1_dat;
      p1 = slot; p1_dat = mdl_mem[va];
      if (ack_due) begin
        if (!ack_we) held_rd = ack_dat;
        ack_due = 0;
      end
      if (grant) begin
        ack_due = 1; ack_we = host_we; ack_dat = mdl_mem[host_addr];
        if (host_we) mdl_mem[host_addr] = host_wdata;
      end
      if (slot) last_addr = va;
      else if (grant) last_addr = host_addr;
      fe_age = fetch_en ? fe_age + 1 : 0;
      if (frame_start) begin
        lines = 0; col = 0; line_had = 0;
      end else if (line_end) begin
        if (line_had || slot) lines++;
        col = 0; line_had = 0;
      end else if (slot) begin
        col++; line_had = 1;
      end
    end
  end

  task automatic host_access(input logic we, input logic [ADDR_W-1:0] a,
                             input logic [DATA_W-1:0] d, output logic [DATA_W-1:0] rd);
    bit got = 0;
    rd = '0;
    @(posedge clk); #1;
    host_req = 1'b1; host_we = we; host_addr = a; host_wdata = d;
    for (int n = 0; n < 8 && !got; n++) begin
      @(negedge clk);
      if (host_ack === 1'b1) begin
        got = 1; rd = host_rdata;
      end
    end
    chk("host_ack_timeout", got, 1);
    @(posedge clk); #1;
    host_req = 1'b0;
  endtask

  task automatic do_line(input bit ck, input int ea, input bit fs);
    @(posedge clk); #1;
    fetch_en = 1'b1; line_end = 1'b1; frame_start = fs;
    @(negedge clk);
    if (ck) chk("row_addr", ram_addr, ea);
    @(posedge clk); #1;
    fetch_en = 1'b0; line_end = 1'b0; frame_start = 1'b0;
  endtask

  task automatic pulse_frame();
    @(posedge clk); #1; frame_start = 1'b1;
    @(posedge clk); #1; frame_start = 1'b0;
  endtask

  task automatic fetch_run(output int cyc[$], output logic [DATA_W-1:0] val[$], output bit cur[$]);
    cyc = {}; val = {}; cur = {};
    for (int k = 0; k < CELL_W * 3; k++) begin
      @(posedge clk); #1; fetch_en = 1'b1;
      @(negedge clk);
      if (k % CELL_W == 0) chk("slot_addr", ram_addr, k / CELL_W);
      if (vid_char_stb) begin
        cyc.push_back(k); val.push_back(vid_char);
`ifdef VRAM_CURSOR_EN
        cur.push_back(vid_cursor);
`else
        cur.push_back(1'b0);
`endif
      end
    end
    @(posedge clk); #1; fetch_en = 1'b0; line_end = 1'b1;
    @(posedge clk); #1; line_end = 1'b0;
  endtask

  initial begin
    int cyc[$];
    logic [DATA_W-1:0] val[$];
    bit cur[$];
    logic [DATA_W-1:0] rd;
    int exp_cyc[3];
    exp_cyc = '{2, 11, 20};
    for (int i = 0; i < DEPTH; i++) begin
      ram_mem[i] = DATA_W'($urandom);
      mdl_mem[i] = ram_mem[i];
    end
    for (int i = 0; i < 3; i++) begin
      ram_mem[i] = DATA_W'(8'h41 + i);
      mdl_mem[i] = ram_mem[i];
    end

    // reset, fetch_en low
    repeat (3) @(posedge clk);
    #1; reset = 1'b0;
    @(negedge clk);
    chk("post_rst_we", ram_we, 0);
    chk("post_rst_ack", host_ack, 0);

    // three cells from a fresh fetch_en rise
    fetch_run(cyc, val, cur);
    chk("stb_count", cyc.size(), 3);
    for (int i = 0; i < 3 && i < cyc.size(); i++) begin
      chk("stb_cycle", cyc[i], exp_cyc[i]);
      chk("stb_char", val[i], 8'h41 + i);
    end

    // host write issued on a slot clock: one clock wait, then grant, then ack
    @(posedge clk); #1;
    fetch_en = 1'b1; host_req = 1'b1; host_we = 1'b1; host_addr = 11'h005; host_wdata = 8'h5A;
    @(negedge clk); chk("hw_slot_we", ram_we, 0);
    @(posedge clk); #1;
    @(negedge clk); chk("hw_grant_we", ram_we, 1); chk("hw_grant_addr", ram_addr, 5);
    @(posedge clk); #1;
    @(negedge clk); chk("hw_ack", host_ack, 1);
    @(posedge clk); #1; host_req = 1'b0; fetch_en = 1'b0;
    host_access(1'b0, 11'h005, 8'h00, rd);
    chk("hr_5A", rd, 8'h5A);

    // row base advance after CHAR_H lines, frame_start beats line_end
    pulse_frame();
    repeat (CHAR_H) do_line(0, 0, 0);
    do_line(1, 80, 0);
    do_line(0, 0, 1);
    do_line(1, 0, 0);

    // row base wrap at the top of the address space
    pulse_frame();
    repeat (25 * CHAR_H) do_line(0, 0, 0);
    do_line(1, 2000, 0);
    repeat (CHAR_H - 1) do_line(0, 0, 0);
    do_line(1, 32, 0);

    // reset in the middle of a host transaction suppresses the ack
    @(posedge clk); #1;
    host_req = 1'b1; host_we = 1'b1; host_addr = 11'h007; host_wdata = 8'h99;
    @(negedge clk); chk("mid_grant_we", ram_we, 1);
    @(posedge clk); #1; reset = 1'b1; host_req = 1'b0;
    @(negedge clk); chk("mid_rst_no_ack", host_ack, 0);
    @(posedge clk); #1;
    @(posedge clk); #1; reset = 1'b0;

`ifdef VRAM_CURSOR_EN
    cursor_addr = 11'd1; cursor_on = 1'b1;
    fetch_run(cyc, val, cur);
    chk("cur_count", cur.size(), 3);
    for (int i = 0; i < 3 && i < cur.size(); i++) chk("cur_on", cur[i], (i == 1));
    pulse_frame();
    cursor_on = 1'b0;
    fetch_run(cyc, val, cur);
    for (int i = 0; i < cur.size(); i++) chk("cur_off", cur[i], 0);
    pulse_frame();
`endif

    // randomized video timing with concurrent host traffic
    fork
      begin
        for (int c = 0; c < 3000; c++) begin
          @(posedge clk); #1;
          if ($urandom_range(0, 15) == 0) fetch_en = ~fetch_en;
          line_end    = ($urandom_range(0, 24) == 0);
          frame_start = ($urandom_range(0, 399) == 0);
        end
        @(posedge clk); #1;
        fetch_en = 1'b0; line_end = 1'b0; frame_start = 1'b0;
      end
      begin
        logic [DATA_W-1:0] hr;
        for (int t = 0; t < 200; t++) begin
          repeat ($urandom_range(0, 6)) @(posedge clk);
          host_access(1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 31)),
                      DATA_W'($urandom), hr);
        end
      end
    join

    repeat (5) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
